// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - funct3 encodings of the RV32I loads/stores handled by the unit
//   - FSM state encoding (also exported on the top's dbg_state output)
//   - legality and misalignment helpers used by the request decode
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Stores only have B/H/W; loads additionally have BU/HU.
  function automatic logic is_illegal(input logic is_store, input logic [2:0] funct3);
    if (is_store) begin
      return (funct3 > F3_W);
    end
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

  // funct3[1:0] encodes the access size (0=byte, 1=half, 2=word).
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_master_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   word       in  32  word read from memory
//   addr_lo    in   2  byte offset within the word
//   funct3     in   3  RV32I funct3 of the access
//   wdata      in  32  store data (low byte/half used for SB/SH)
//   load_data  out 32  extracted and sign/zero-extended load value
//   store_word out 32  word with the addressed byte/half replaced by wdata
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase
  end

  always_comb begin
    store_word = word;
    case (funct3)
      F3_B: begin
        case (addr_lo)
          2'd0: store_word[7:0]   = wdata[7:0];
          2'd1: store_word[15:8]  = wdata[7:0];
          2'd2: store_word[23:16] = wdata[7:0];
          2'd3: store_word[31:24] = wdata[7:0];
          default: store_word = word;
        endcase
      end
      F3_H: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: RV32I load/store unit driving a word-only data memory.
//   clk, rst_n          clock, asynchronous active-low reset
//   req_*               request from execute stage (valid/ready)
//   resp_*              completion pulse with load data / error flag
//   mem_*               word interface to dmem (combinational read data)
//   dbg_state           current FSM state for observation
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE; the core holds
// req_valid (and the request fields) until the transfer. resp_valid is a
// one-cycle pulse; resp_rdata/resp_err are meaningful only with it.
//
// Flow: IDLE -> RESP for illegal/misaligned requests (no memory access),
// IDLE -> RD -> RESP for loads, IDLE -> WR -> RESP for SW and
// IDLE -> RD -> WR -> RESP for SB/SH (read-modify-write).
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [1:0]      dbg_state
);

  lsu_state_e state, state_next;

  logic            is_store_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] wbuf;

  logic            accept;
  logic            req_bad;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] store_word;

  assign accept  = req_valid && (state == ST_IDLE);
  assign req_bad = is_illegal(req_is_store, req_funct3) ||
                   is_misaligned(req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .word       (mem_rdata),
    .addr_lo    (addr_q[1:0]),
    .funct3     (funct3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state plus Moore output decode.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (req_bad)                                     state_next = ST_RESP;
          else if (req_is_store && (req_funct3 == F3_W))   state_next = ST_WR;
          else                                             state_next = ST_RD;
        end
      end
      ST_RD: begin
        mem_read   = 1'b1;
        state_next = is_store_q ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        mem_write  = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
  // SW writes the store data directly; SB/SH write the merged word.
  assign mem_wdata = (state != ST_WR)    ? '0 :
                     (funct3_q == F3_W)  ? wdata_q : wbuf;
  assign dbg_state = state;

  // Response registers only change on the edge that enters RESP, so they
  // hold the previous response while a new request is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      wbuf       <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            if (req_bad) begin
              resp_rdata <= '0;
              resp_err   <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (is_store_q) begin
            wbuf <= store_word;
          end else begin
            resp_rdata <= load_data;
            resp_err   <= 1'b0;
          end
        end
        ST_WR: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master with a 16-word dmem attached. A byte-level
// reference memory predicts load results, store effects, latency and the
// number of memory read/write cycles of each request.
module tb_lsu_mem_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  lsu_mem_master dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- dmem ----------------
  logic [31:0] dmem [16];
  assign mem_rdata = mem_read ? dmem[mem_addr[5:2]] : 32'h0;
  always @(posedge clk) begin
    if (mem_write) dmem[mem_addr[5:2]] <= mem_wdata;
  end

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  int resp_seen = 0;
  int wr_total = 0;

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_lat_q[$];
  int          exp_rd_q[$];
  int          exp_wr_q[$];

  logic [7:0] ref_bytes [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
  endfunction

  // Reference model: byte-addressed memory, access size 1/2/4 bytes.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    logic legal;
    int size, base;
    logic [31:0] v;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    base  = int'(addr[5:0]);
    if (!legal || (int'(addr[1:0]) % size) != 0) begin
      exp_q.push_back(32'h0); exp_err_q.push_back(1'b1);
      exp_lat_q.push_back(1); exp_rd_q.push_back(0); exp_wr_q.push_back(0);
    end else if (!st) begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_bytes[base+i]) << (8*i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      exp_q.push_back(v); exp_err_q.push_back(1'b0);
      exp_lat_q.push_back(2); exp_rd_q.push_back(1); exp_wr_q.push_back(0);
    end else begin
      for (int i = 0; i < size; i++) ref_bytes[base+i] = wd[8*i +: 8];
      exp_q.push_back(32'h0); exp_err_q.push_back(1'b0);
      exp_lat_q.push_back(size == 4 ? 2 : 3);
      exp_rd_q.push_back(size == 4 ? 0 : 1);
      exp_wr_q.push_back(1);
    end
  endtask

  // ---------------- monitor ----------------
  int  lat, rd_cnt, wr_cnt;
  logic pending = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
    end else begin
      if (mem_write) wr_total++;
      if (pending) begin
        lat++;
        if (mem_read)  rd_cnt++;
        if (mem_write) wr_cnt++;
      end
      if (mem_read && mem_write) check("rd_wr_exclusive", 32'(mem_read & mem_write), 32'h0);
      if (resp_valid) begin
        resp_seen++;
        if (exp_q.size() == 0) begin
          check("spurious_resp", 32'(resp_valid), 32'h0);
        end else begin
          check("resp_rdata", resp_rdata, exp_q.pop_front());
          check("resp_err", 32'(resp_err), 32'(exp_err_q.pop_front()));
          check("latency", 32'(lat), 32'(exp_lat_q.pop_front()));
          check("rd_cycles", 32'(rd_cnt), 32'(exp_rd_q.pop_front()));
          check("wr_cycles", 32'(wr_cnt), 32'(exp_wr_q.pop_front()));
        end
        pending = 1'b0;
      end
      if (req_valid && req_ready) begin
        pending = 1'b1;
        lat = 0; rd_cnt = 0; wr_cnt = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    @(posedge clk); #1;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    int start;
    model(st, f3, addr, wd);
    start = resp_seen;
    drive(st, f3, addr, wd);
    for (int i = 0; i < 20 && resp_seen == start; i++) @(posedge clk);
    if (resp_seen == start) begin
      check("resp_timeout", 32'(resp_seen - start), 32'h1);
      void'(exp_q.pop_back()); void'(exp_err_q.pop_back()); void'(exp_lat_q.pop_back());
      void'(exp_rd_q.pop_back()); void'(exp_wr_q.pop_back());
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic        st;
    int          before_resp, before_wr;
    logic [2:0]  legal_ld [5];
    legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int w = 0; w < 16; w++) dmem[w] = 32'h0;
    for (int b = 0; b < 64; b++) ref_bytes[b] = 8'h0;
    dmem[0] = 32'hDEADBEEF;
    ref_bytes[0] = 8'hEF; ref_bytes[1] = 8'hBE; ref_bytes[2] = 8'hAD; ref_bytes[3] = 8'hDE;

    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'h0);
    check("rst_mem_read", 32'(mem_read), 32'h0);
    check("rst_mem_write", 32'(mem_write), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    #2 rst_n = 1'b1;

    // Directed: loads from word0 = DEADBEEF
    issue(0, 3'd0, 32'h3, 32'h0);          // LB  -> FFFFFFDE
    issue(0, 3'd4, 32'h3, 32'h0);          // LBU -> 000000DE
    issue(0, 3'd1, 32'h0, 32'h0);          // LH  -> FFFFBEEF
    issue(0, 3'd5, 32'h2, 32'h0);          // LHU -> 0000DEAD
    issue(0, 3'd2, 32'h0, 32'h0);          // LW  -> DEADBEEF
    // Stores
    issue(1, 3'd0, 32'h1, 32'h000000AA);   // SB
    issue(0, 3'd2, 32'h0, 32'h0);          // -> DEADAAEF
    check("word0_after_sb", dmem[0], 32'hDEADAAEF);
    issue(1, 3'd1, 32'h6, 32'hFFFF1234);   // SH
    check("word1_after_sh", dmem[1], 32'h12340000);
    issue(1, 3'd2, 32'h4, 32'hCAFEF00D);   // SW
    check("word1_after_sw", dmem[1], 32'hCAFEF00D);
    // Errors
    issue(0, 3'd2, 32'h5, 32'h0);          // misaligned LW
    issue(1, 3'd1, 32'h3, 32'h5555);       // misaligned SH
    issue(0, 3'd3, 32'h0, 32'h0);          // illegal load funct3
    issue(1, 3'd4, 32'h0, 32'h0);          // illegal store funct3
    check("word0_after_err", dmem[0], 32'hDEADAAEF);

    // Reset while SB sits in RD: no write, no response.
    before_resp = resp_seen;
    before_wr   = wr_total;
    drive(1, 3'd0, 32'h0, 32'h11);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_req_ready", 32'(req_ready), 32'h1);
    check("abort_no_write", 32'(wr_total - before_wr), 32'h0);
    check("abort_no_resp", 32'(resp_seen - before_resp), 32'h0);
    check("abort_word0", dmem[0], ref_word(0));
    issue(0, 3'd2, 32'h0, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) f3 = st ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)];
      else                          f3 = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'h1 << f3[1:0]) - 32'h1);
      issue(st, f3, a, $urandom);
    end

    for (int w = 0; w < 16; w++) check("final_mem", dmem[w], ref_word(w));
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
